// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - PC holder and ZF/CF conditional-branch resolver; optional counters under BRANCH_STATS_EN
module branch_resolve_unit #(
  parameter int              PC_W         = 10,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            enable,
  input  logic            halt,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            cmp_busy,
  input  logic            ZF,
  input  logic            CF,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            flush,
  output logic            illegal,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     nottaken_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [2:0] COND_RSVD  = 3'b111;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [2:0]      cond_q, cond_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            resolve_en;
  logic            res_taken;
  logic [2:0]      res_cond;
  logic [PC_W-1:0] res_target;
  logic [PC_W-1:0] pc_inc;

  // Condition table; the reserved code never jumps.
  function automatic logic cond_met(input logic [2:0] c, input logic zf, input logic cf);
    logic r;
    r = 1'b0;
    case (c)
      3'b000:  r = 1'b1;
      3'b001:  r = zf;
      3'b010:  r = ~zf;
      3'b011:  r = cf;
      3'b100:  r = ~cf;
      3'b101:  r = ~cf & ~zf;
      3'b110:  r = cf | zf;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign br_ready = (state_q == ST_RUN) & enable & ~halt;
  assign accept   = br_valid & br_ready;
  assign pc_inc   = pc_q + PC_W'(1);

  // A deferred branch uses its latched cond/target; an immediate one uses the live request.
  assign res_cond   = (state_q == ST_RESOLVE) ? cond_q   : br_cond;
  assign res_target = (state_q == ST_RESOLVE) ? target_q : br_target;
  assign res_taken  = cond_met(res_cond, ZF, CF);

  assign pc      = pc_q;
  assign taken   = taken_q;
  assign illegal = illegal_q;
  assign flush   = (state_q == ST_FLUSH);

  // Next-state, next-PC and pulse computation; halt overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cond_d     = cond_q;
    target_d   = target_q;
    fcnt_d     = fcnt_q;
    taken_d    = 1'b0;
    illegal_d  = 1'b0;
    resolve_en = 1'b0;

    if (halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enable) begin
            if (accept && cmp_busy) begin
              cond_d   = br_cond;
              target_d = br_target;
              state_d  = ST_RESOLVE;
            end else if (accept) begin
              resolve_en = 1'b1;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        ST_RESOLVE: begin
          resolve_en = 1'b1;
        end
        ST_FLUSH: begin
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase

      if (resolve_en) begin
        if (res_taken) begin
          pc_d    = res_target;
          taken_d = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          pc_d      = pc_inc;
          illegal_d = (res_cond == COND_RSVD);
          state_d   = ST_RUN;
        end
      end
    end
  end

  // State, PC, latched branch and registered pulses.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      cond_q    <= 3'd0;
      target_q  <= '0;
      fcnt_q    <= 3'd0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      fcnt_q    <= fcnt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] ncnt_q, ncnt_d;

  // Saturating per-outcome counters, bumped once per resolved branch.
  always_comb begin
    tcnt_d = tcnt_q;
    ncnt_d = ncnt_q;
    if (resolve_en && !halt) begin
      if (res_taken) begin
        if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
      end else begin
        if (ncnt_q != 16'hFFFF) ncnt_d = ncnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tcnt_q <= 16'd0;
      ncnt_q <= 16'd0;
    end else begin
      tcnt_q <= tcnt_d;
      ncnt_q <= ncnt_d;
    end
  end

  assign taken_cnt    = tcnt_q;
  assign nottaken_cnt = ncnt_q;
`else
  assign taken_cnt    = 16'd0;
  assign nottaken_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int PC_W   = 10;
  localparam int FC     = 1;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk = 1'b0;
  logic            clear;
  logic            enable;
  logic            halt;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            cmp_busy;
  logic            ZF;
  logic            CF;
  logic [PC_W-1:0] pc;
  logic            taken;
  logic            flush;
  logic            illegal;
  logic [15:0]     taken_cnt;
  logic [15:0]     nottaken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W(PC_W),
    .RESET_PC('0),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .clear(clear),
    .enable(enable),
    .halt(halt),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_cond(br_cond),
    .br_target(br_target),
    .cmp_busy(cmp_busy),
    .ZF(ZF),
    .CF(CF),
    .pc(pc),
    .taken(taken),
    .flush(flush),
    .illegal(illegal),
    .taken_cnt(taken_cnt),
    .nottaken_cnt(nottaken_cnt)
  );

  // Behavioural model: program counter, a pending deferred branch, remaining flush cycles, halted flag.
  int m_pc;
  bit m_taken;
  bit m_illegal;
  bit m_halted;
  bit m_pend;
  int m_cond;
  int m_tgt;
  int m_flush_left;
  int m_tc;
  int m_nc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit branch_goes(input int c, input bit zf, input bit cf);
    bit below;
    bit equal;
    below = cf;
    equal = zf;
    case (c)
      0: return 1'b1;
      1: return equal;
      2: return !equal;
      3: return below;
      4: return !below;
      5: return !below && !equal;
      6: return below || equal;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_taken = 0; m_illegal = 0; m_halted = 0; m_pend = 0;
    m_cond = 0; m_tgt = 0; m_flush_left = 0; m_tc = 0; m_nc = 0;
  endtask

  function automatic bit model_ready();
    return !m_halted && !m_pend && (m_flush_left == 0) && enable && !halt;
  endfunction

  task automatic model_resolve(input int c, input int t);
    if (branch_goes(c, ZF, CF)) begin
      m_pc = t;
      m_taken = 1;
      m_flush_left = FC;
      if (m_tc < 65535) m_tc++;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
      m_illegal = (c == 7);
      if (m_nc < 65535) m_nc++;
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = br_valid && model_ready();
    m_taken = 0;
    m_illegal = 0;
    if (halt) begin
      m_halted = 1; m_pend = 0; m_flush_left = 0;
    end else if (m_halted) begin
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_pend) begin
      m_pend = 0;
      model_resolve(m_cond, m_tgt);
    end else if (enable) begin
      if (acc && cmp_busy) begin
        m_pend = 1; m_cond = int'(br_cond); m_tgt = int'(br_target);
      end else if (acc) begin
        model_resolve(int'(br_cond), int'(br_target));
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
  endtask

  task automatic check_outputs();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("taken", 32'(taken), 32'(m_taken));
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("illegal", 32'(illegal), 32'(m_illegal));
`ifdef BRANCH_STATS_EN
    chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
    chk("nottaken_cnt", 32'(nottaken_cnt), 32'(m_nc));
`else
    chk("taken_cnt", 32'(taken_cnt), 32'd0);
    chk("nottaken_cnt", 32'(nottaken_cnt), 32'd0);
`endif
  endtask

  // One clock: drive inputs, compare br_ready, advance the model, compare registered outputs.
  task automatic step(input bit en, input bit hl, input bit v, input int c, input int t,
                      input bit busy, input bit zf, input bit cf, output bit rdy);
    enable = en; halt = hl; br_valid = v; br_cond = 3'(c); br_target = PC_W'(t);
    cmp_busy = busy; ZF = zf; CF = cf;
    #1;
    rdy = br_ready;
    chk("br_ready", 32'(br_ready), 32'(model_ready()));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit r;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Asserts clear in the middle of a cycle, after the active edge.
  task automatic clear_mid_cycle();
    @(posedge clk);
    #2;
    clear = 1'b1;
    #1;
    chk("flush_async_clear", 32'(flush), 32'd0);
    chk("pc_async_clear", 32'(pc), 32'd0);
    model_reset();
    check_outputs();
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    bit rdy;
    bit en, hl, v, busy, zf, cf;
    int c, t;

    clear = 1'b1; enable = 1'b0; halt = 1'b0; br_valid = 1'b0;
    br_cond = 3'd0; br_target = '0; cmp_busy = 1'b0; ZF = 1'b0; CF = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_taken", 32'(taken), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    check_outputs();
    clear = 1'b0;
    enable = 1'b1;
    #1;
    chk("ready_after_clear", 32'(br_ready), 32'd1);

    // Free-running count and wrap.
    for (int i = 1; i <= 1024; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, rdy);
      if (i == 1023) chk("pc_1023", 32'(pc), 32'd1023);
      if (i == 1024) chk("pc_wrap", 32'(pc), 32'd0);
    end

    // JE taken with ZF=1 and a one-cycle flush window.
    step(1, 0, 1, 1, 'h2A, 0, 1, 0, rdy);
    chk("je_pc", 32'(pc), 32'h2A);
    chk("je_taken", 32'(taken), 32'd1);
    chk("je_flush", 32'(flush), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, rdy);
    chk("ready_in_flush", 32'(rdy), 32'd0);
    chk("flush_end", 32'(flush), 32'd0);
    chk("pc_held_flush", 32'(pc), 32'h2A);
    idle(1);
    chk("pc_after_flush", 32'(pc), 32'h2B);

    // JB not taken, then JA taken from the same starting point.
    do_clear();
    idle(5);
    chk("pc_5", 32'(pc), 32'd5);
    step(1, 0, 1, 3, 'h123, 0, 0, 0, rdy);
    chk("jb_pc", 32'(pc), 32'd6);
    chk("jb_taken", 32'(taken), 32'd0);
    chk("jb_flush", 32'(flush), 32'd0);
    do_clear();
    idle(5);
    step(1, 0, 1, 5, 'h123, 0, 0, 0, rdy);
    chk("ja_pc", 32'(pc), 32'h123);
    chk("ja_taken", 32'(taken), 32'd1);
    idle(2);

    // Deferred resolve while a compare is in flight.
    do_clear();
    idle(5);
    step(1, 0, 1, 1, 'h77, 1, 0, 0, rdy);
    chk("resolve_pc_hold", 32'(pc), 32'd5);
    chk("resolve_taken0", 32'(taken), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, rdy);
    chk("resolve_ready", 32'(rdy), 32'd0);
    chk("resolve_pc", 32'(pc), 32'h77);
    chk("resolve_taken", 32'(taken), 32'd1);
    idle(2);

    // Reserved code, then halt over a same-cycle branch.
    do_clear();
    idle(9);
    step(1, 0, 1, 7, 'h55, 0, 1, 1, rdy);
    chk("rsvd_pc", 32'(pc), 32'd10);
    chk("rsvd_illegal", 32'(illegal), 32'd1);
    chk("rsvd_taken", 32'(taken), 32'd0);
    step(1, 1, 1, 0, 'h66, 0, 0, 0, rdy);
    chk("halt_pc", 32'(pc), 32'd10);
    chk("halt_taken", 32'(taken), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 'h66, 0, 0, 0, rdy);
      chk("halted_pc", 32'(pc), 32'd10);
      chk("halted_ready", 32'(rdy), 32'd0);
    end
    do_clear();
    chk("unhalt_pc", 32'(pc), 32'd0);

    // Counters over 3 taken + 2 not taken, then clear during flush.
    idle(2);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 'h100 + i, 0, 0, 0, rdy);
      idle(1);
    end
    step(1, 0, 1, 3, 'h10, 0, 0, 0, rdy);
    step(1, 0, 1, 6, 'h10, 0, 0, 0, rdy);
`ifdef BRANCH_STATS_EN
    chk("stat_taken_3", 32'(taken_cnt), 32'd3);
    chk("stat_nottaken_2", 32'(nottaken_cnt), 32'd2);
`endif
    step(1, 0, 1, 0, 'h3C0, 0, 0, 0, rdy);
    chk("mid_flush_flush", 32'(flush), 32'd1);
    clear_mid_cycle();
    chk("cleared_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("cleared_nottaken_cnt", 32'(nottaken_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      en   = ($urandom_range(0, 99) < 85);
      hl   = ($urandom_range(0, 299) == 0);
      v    = ($urandom_range(0, 1) == 1);
      c    = int'($urandom_range(0, 7));
      t    = int'($urandom_range(0, PC_MOD - 1));
      busy = ($urandom_range(0, 9) < 3);
      zf   = ($urandom_range(0, 1) == 1);
      cf   = ($urandom_range(0, 1) == 1);
      step(en, hl, v, c, t, busy, zf, cf, rdy);
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the ZF/CF flag interface: holds the program counter and resolves conditional jumps from the registered comparator flags.
- Sits between decode and instruction-memory addressing.
- Accepts one branch request at a time via a valid/ready handshake.
- Stalls one cycle when a compare is still in flight, and drives a flush window after taken branches.

Parameters:
- PC_W, 10, program counter / branch target width in bits.
- RESET_PC, 0, PC value loaded on clear.
- FLUSH_CYCLES, 1, cycles flush is held after a taken branch (0..7; 0 = no flush state).

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- enable  input  1  PC advance enable; 0 freezes PC in RUN.
- halt  input  1  enter HALTED; exit only via clear.
- br_valid  input  1  branch request present.
- br_ready  output  1  branch request can be accepted this cycle.
- br_cond  input  3  condition code, see Behaviour.
- br_target  input  PC_W  jump target address.
- cmp_busy  input  1  CMPsignal asserted this cycle; flags not yet updated.
- ZF  input  1  registered zero/equal flag.
- CF  input  1  registered carry/less-than flag.
- pc  output  PC_W  current program counter.
- taken  output  1  one-cycle pulse, branch taken.
- flush  output  1  squash fetched instructions.
- illegal  output  1  one-cycle pulse, reserved br_cond accepted.
- taken_cnt  output  16  taken-branch count (optional feature).
- nottaken_cnt  output  16  not-taken-branch count (optional feature).

Behaviour:
- Reset (clear=1, async):
  - pc=RESET_PC; state=RUN; FLUSH counter=0.
  - taken=0, flush=0, illegal=0; counters=0.
  - br_ready=1 once clear deasserts.
- br_ready = (state==RUN) & enable & ~halt. Accept = br_valid & br_ready.
- Condition codes:
  - 000 JMP: always.
  - 001 JE: ZF.
  - 010 JNE: ~ZF.
  - 011 JB: CF.
  - 100 JAE: ~CF.
  - 101 JA: ~CF & ~ZF.
  - 110 JBE: CF | ZF.
  - 111 reserved: never taken; illegal pulse.
- States: RUN, RESOLVE, FLUSH, HALTED.
- RUN:
  - enable=0: pc holds; nothing accepted.
  - enable=1, no accept: pc <= pc+1, wrapping modulo 2^PC_W (all-ones -> 0).
  - Accept with cmp_busy=1: latch cond/target; pc holds; -> RESOLVE.
  - Accept with cmp_busy=0: evaluate with current ZF/CF next edge.
    - Taken: pc <= target, taken=1 for one cycle, -> FLUSH (or stay RUN if FLUSH_CYCLES=0).
    - Not taken: pc <= pc+1.
- RESOLVE:
  - Exactly one cycle; evaluates latched cond against ZF/CF as updated by the pending compare.
  - Same taken/not-taken outcome as RUN; enable ignored.
- FLUSH:
  - flush=1; pc holds; counter loaded with FLUSH_CYCLES on entry, decrements each cycle.
  - -> RUN on the cycle counter reaches 1. Total flush-high cycles = FLUSH_CYCLES.
- HALTED:
  - halt has priority over all states and over a same-cycle accept; the accept is dropped.
  - pc holds; br_ready=0, flush=0; leaves only on clear.
- Pulse timing:
  - taken and illegal are registered and high exactly one cycle, the same cycle pc shows the new value.
- Branch to the current pc is legal (self-loop).
- clear mid-RESOLVE/FLUSH abandons the branch immediately.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: taken_cnt/nottaken_cnt increment per resolved branch (reserved code counts as not taken); saturate at 16'hFFFF; cleared by clear.
- Undefined: no counter logic; both outputs tied to 0.

Test Plan:
- clear, enable=1, no branches, PC_W=10 -> pc counts 0,1,2…; after 1023 wraps to 0; br_ready=1 throughout.
- ZF=1, br_cond=001, target=0x2A, cmp_busy=0 -> next edge pc=0x2A, taken=1 one cycle, flush=1 for 1 cycle, br_ready=0 during flush.
- pc=5, ZF=0, CF=0, br_cond=011 -> pc=6, taken=0, flush=0; same cycle br_cond=101 instead -> pc=target.
- Accept br_cond=001 with cmp_busy=1, old ZF=0, ZF becomes 1 next cycle -> one RESOLVE cycle (pc holds), then pc=target, taken=1.
- br_cond=111 at pc=9 -> pc=10, illegal=1 one cycle, taken=0; halt=1 concurrent with valid branch -> HALTED, pc frozen until clear, then pc=RESET_PC.
- BRANCH_STATS_EN: 3 taken + 2 not-taken -> taken_cnt=3, nottaken_cnt=2; assert clear mid-FLUSH -> all zero, flush=0 immediately.
